trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_pkg.sv | 48 ++++
 rtl/trap_ctrl_if.sv | 37 +++
 rtl/trap_csr_regs.sv | 105 ++++++++++
 rtl/trap_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trap_ctrl_pkg
//  Purpose  : Shared constants, cause codes and FSM state type for trap control
//  Revision : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

    // PC mux select encodings shared with the fetch stage
    localparam logic [1:0] PC_BOOT = 2'd0;
    localparam logic [1:0] PC_EPC  = 2'd1;
    localparam logic [1:0] PC_TRAP = 2'd2;
    localparam logic [1:0] PC_NEXT = 2'd3;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] EXC_INSTR_FAULT    = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL_INSTR  = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;
    localparam logic [3:0] EXC_ECALL_M        = 4'd11;

    localparam logic [3:0]  IRQ_CAUSE_EXT  = 4'd11;
    localparam logic [31:0] MCAUSE_IRQ_EXT = {1'b1, 27'b0, IRQ_CAUSE_EXT};

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2,
        ST_RET  = 2'd3
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : trap_ctrl_if
//  Purpose  : Pipeline-facing event, CSR and redirect signals of trap_ctrl
//  Revision : 1.0 - initial release
// ============================================================================
interface trap_ctrl_if;

    logic        exc_req;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        irq_ext;
    logic [31:0] irq_pc;
    logic        mret_req;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [1:0]  pc_sel;
    logic [31:0] trap_vec;
    logic [31:0] epc;
    logic        flush;

    modport master (
        output exc_req, exc_cause, exc_pc, irq_ext, irq_pc, mret_req,
               csr_we, csr_addr, csr_wdata,
        input  csr_rdata, pc_sel, trap_vec, epc, flush
    );

    modport slave (
        input  exc_req, exc_cause, exc_pc, irq_ext, irq_pc, mret_req,
               csr_we, csr_addr, csr_wdata,
        output csr_rdata, pc_sel, trap_vec, epc, flush
    );

endinterface
`default_nettype wire

// File: rtl/trap_csr_regs.sv
`default_nettype none
// ============================================================================
//  Module   : trap_csr_regs
//  Purpose  : Machine trap CSR storage (mstatus/mtvec/mepc/mcause) and read mux
//  Revision : 1.0 - initial release
// ============================================================================
module trap_csr_regs
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_trap_exc,
    input  wire logic        i_trap_irq,
    input  wire logic        i_mret,
    input  wire logic [3:0]  i_exc_cause,
    input  wire logic [31:0] i_exc_pc,
    input  wire logic [31:0] i_irq_pc,
    input  wire logic        i_csr_we,
    input  wire logic [11:0] i_csr_addr,
    input  wire logic [31:0] i_csr_wdata,
    output logic      [31:0] o_csr_rdata,
    output logic      [31:0] o_mtvec,
    output logic      [31:0] o_mepc,
    output logic             o_mie
);

    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic        r_mie;
    logic        r_mpie;

    logic w_wr_mstatus;
    logic w_wr_mtvec;
    logic w_wr_mepc;
    logic w_wr_mcause;

    assign w_wr_mstatus = i_csr_we && (i_csr_addr == CSR_MSTATUS);
    assign w_wr_mtvec   = i_csr_we && (i_csr_addr == CSR_MTVEC);
    assign w_wr_mepc    = i_csr_we && (i_csr_addr == CSR_MEPC);
    assign w_wr_mcause  = i_csr_we && (i_csr_addr == CSR_MCAUSE);

    // Trap and MRET updates sit above software writes in each if-chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtvec  <= RESET_MTVEC;
            r_mepc   <= 32'h0;
            r_mcause <= 32'h0;
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
        end else begin
            if (w_wr_mtvec) begin
                r_mtvec <= word_align(i_csr_wdata);
            end

            if (i_trap_exc) begin
                r_mepc   <= word_align(i_exc_pc);
                r_mcause <= {28'b0, i_exc_cause};
            end else if (i_trap_irq) begin
                r_mepc   <= word_align(i_irq_pc);
                r_mcause <= MCAUSE_IRQ_EXT;
            end else begin
                if (w_wr_mepc) begin
                    r_mepc <= word_align(i_csr_wdata);
                end
                if (w_wr_mcause) begin
                    r_mcause <= i_csr_wdata;
                end
            end

            if (i_trap_exc || i_trap_irq) begin
                r_mpie <= r_mie;
                r_mie  <= 1'b0;
            end else if (i_mret) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_wr_mstatus) begin
                r_mie  <= i_csr_wdata[MSTATUS_MIE_BIT];
                r_mpie <= i_csr_wdata[MSTATUS_MPIE_BIT];
            end
        end
    end

    always_comb begin
        o_csr_rdata = 32'h0;
        case (i_csr_addr)
            CSR_MSTATUS: begin
                o_csr_rdata[MSTATUS_MIE_BIT]  = r_mie;
                o_csr_rdata[MSTATUS_MPIE_BIT] = r_mpie;
            end
            CSR_MTVEC:  o_csr_rdata = r_mtvec;
            CSR_MEPC:   o_csr_rdata = r_mepc;
            CSR_MCAUSE: o_csr_rdata = r_mcause;
            default:    o_csr_rdata = 32'h0;
        endcase
    end

    assign o_mtvec = r_mtvec;
    assign o_mepc  = r_mepc;
    assign o_mie   = r_mie;

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trap_ctrl
//  Purpose  : Machine-mode trap/return sequencer driving the PC mux and flush
//  Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    trap_ctrl_if.slave bus
);

    state_t r_state;
    state_t w_state_next;

    logic w_mie;
    logic w_run;
    logic w_take_exc;
    logic w_take_irq;
    logic w_take_mret;

    // Events only count in RUN; priority is exception, then interrupt, then MRET.
    assign w_run       = (r_state == ST_RUN);
    assign w_take_exc  = w_run && bus.exc_req;
    assign w_take_irq  = w_run && !bus.exc_req && bus.irq_ext && w_mie;
    assign w_take_mret = w_run && !bus.exc_req && !(bus.irq_ext && w_mie) && bus.mret_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_RUN;
        bus.pc_sel   = PC_NEXT;
        bus.flush    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                bus.pc_sel = PC_BOOT;
                bus.flush  = 1'b1;
            end
            ST_RUN: begin
                if (w_take_exc || w_take_irq) begin
                    w_state_next = ST_TRAP;
                end else if (w_take_mret) begin
                    w_state_next = ST_RET;
                end
            end
            ST_TRAP: begin
                bus.pc_sel = PC_TRAP;
                bus.flush  = 1'b1;
            end
            ST_RET: begin
                bus.pc_sel = PC_EPC;
                bus.flush  = 1'b1;
            end
            default: begin
                w_state_next = ST_BOOT;
                bus.pc_sel   = PC_BOOT;
                bus.flush    = 1'b1;
            end
        endcase
    end

    trap_csr_regs #(
        .RESET_MTVEC (RESET_MTVEC)
    ) u_csr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_trap_exc  (w_take_exc),
        .i_trap_irq  (w_take_irq),
        .i_mret      (w_take_mret),
        .i_exc_cause (bus.exc_cause),
        .i_exc_pc    (bus.exc_pc),
        .i_irq_pc    (bus.irq_pc),
        .i_csr_we    (bus.csr_we),
        .i_csr_addr  (bus.csr_addr),
        .i_csr_wdata (bus.csr_wdata),
        .o_csr_rdata (bus.csr_rdata),
        .o_mtvec     (bus.trap_vec),
        .o_mepc      (bus.epc),
        .o_mie       (w_mie)
    );

endmodule
`default_nettype wire
